controlador_display_bcd: RTL and testbench
==========================================

// Module: controlador_display_bcd
// PURPOSE
//  Sequencer for the binary-to-decimal display path. Accepts a 7-bit binary value (0..127)
//  over a valid/ready handshake and splits it into hundreds/tens/units digits by multi-cycle
//  repeated subtraction. Double-buffers the result and time-multiplexes the three digits onto
//  one shared digit bus with active-low anode selects. The downstream 7-segment decoder
//  consumes digito/anodo.
// PARAMETERS
//  REFRESH_DIV  50000  clock cycles each digit stays selected before the scan advances (>=2)
// PORTS
//  clk        in   1  single system clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  in_valor is valid this cycle
//  in_ready   out  1  block can accept a new value
//  in_valor   in   7  binary value to convert, 0..127
//  centena    out  4  latched hundreds digit of the last completed conversion (0/1)
//  dezena     out  4  latched tens digit (0..9)
//  unidade    out  4  latched units digit (0..9)
//  bcd_valid  out  1  one-cycle pulse when centena/dezena/unidade update
//  digito     out  4  digit currently driven on the shared bus (4'hF = blank code)
//  anodo      out  3  active-low one-hot select: [0]=units, [1]=tens, [2]=hundreds
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-conversion): FSM->IDLE, conversion aborted and discarded.
//    Outputs: in_ready=1, centena=dezena=unidade=0, bcd_valid=0, scan counter=0,
//    anodo=3'b110, digito=0.
//  - FSM: IDLE -> CONV on in_valid&&in_ready (in_valor captured into a 7-bit residue,
//    digit accumulators cleared); CONV -> DONE when residue<10; DONE -> IDLE unconditionally.
//  - in_ready=1 only in IDLE; in_valid while in CONV/DONE is ignored, never queued.
//  - Each CONV cycle performs exactly one step: residue>=100: residue-=100, hundreds+=1;
//    else residue>=10: residue-=10, tens+=1; else units=residue[3:0] and go to DONE.
//  - Latency accept->bcd_valid = (hundreds + tens + 2) cycles. Values: 0 -> 2 cycles,
//    9 -> 2, 10 -> 3, 99 -> 11, 127 -> 5 (1 hundred + 2 tens + final + DONE).
//  - In DONE: centena/dezena/unidade load from the accumulators; bcd_valid=1 for that single
//    cycle. Latched outputs hold until the next DONE and never show partial values.
//  - Scan: a counter runs 0..REFRESH_DIV-1 continuously (independent of the FSM). On wrap
//    the select rotates units->tens->hundreds->units; anodo has exactly one bit low at all
//    times. digito is the latched digit for the selected position, updated in the same cycle
//    as anodo. A new result appears on the bus without disturbing scan phase.
//  - All arithmetic is unsigned; the residue never underflows because every subtraction is
//    guarded by a compare.
// CONFIGURATION
//  BLANK_ZEROS_EN defined:
//   - digito=4'hF when the hundreds position is selected and centena==0.
//   - digito=4'hF when the tens position is selected and centena==0 && dezena==0.
//   - Units are never blanked. anodo is unchanged.
//  BLANK_ZEROS_EN undefined: all three digits are always driven with their value; 4'hF is
//   never emitted.
// TESTING
//  1. rst held 2 cycles -> in_ready=1, anodo=3'b110, digito=0, centena/dezena/unidade=0.
//  2. in_valor=127 with in_valid -> bcd_valid pulse 5 cycles later; centena=1, dezena=2,
//     unidade=7.
//  3. in_valor=99, then in_valid=1 with in_valor=5 held during CONV -> result 0/9/9 after
//     11 cycles; the 5 is accepted only after in_ready returns to 1, giving 0/0/5.
//  4. REFRESH_DIV=4, result 1/2/7 -> anodo 110,101,011 each held 4 cycles; digito 7,2,1.
//  5. rst asserted in the 3rd CONV cycle of in_valor=99 -> no bcd_valid; outputs at reset
//     values next cycle.
//  6. BLANK_ZEROS_EN, in_valor=5, REFRESH_DIV=4 -> digito 5,F,F; without macro -> 5,0,0.

Source files
------------

// File: rtl/controlador_display_bcd.sv
// Binary (0..127) to hundreds/tens/units converter by repeated subtraction, with a
// time-multiplexed digit bus. Optional macro BLANK_ZEROS_EN blanks leading zeros (4'hF).
module controlador_display_bcd #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_valor,
    output logic [3:0] centena,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output logic       bcd_valid,
    output logic [3:0] digito,
    output logic [2:0] anodo
);
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t     state, state_nx;
    logic [6:0] residue;
    logic [3:0] acc_c, acc_d, acc_u;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0] scan_sel;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CONV;
            end
            CONV:    if (residue < 7'd10) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One subtraction step per CONV cycle; results become visible only from DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            residue   <= '0;
            acc_c     <= '0;
            acc_d     <= '0;
            acc_u     <= '0;
            centena   <= '0;
            dezena    <= '0;
            unidade   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    residue <= in_valor;
                    acc_c   <= '0;
                    acc_d   <= '0;
                    acc_u   <= '0;
                end
                CONV: begin
                    if (residue >= 7'd100) begin
                        residue <= residue - 7'd100;
                        acc_c   <= acc_c + 4'd1;
                    end else if (residue >= 7'd10) begin
                        residue <= residue - 7'd10;
                        acc_d   <= acc_d + 4'd1;
                    end else begin
                        acc_u <= residue[3:0];
                    end
                end
                DONE: begin
                    centena   <= acc_c;
                    dezena    <= acc_d;
                    unidade   <= acc_u;
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Scan runs free of the FSM so new results never shift the refresh phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_sel <= 2'd0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            scan_sel <= (scan_sel == 2'd2) ? 2'd0 : scan_sel + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        anodo  = 3'b110;
        digito = unidade;
        case (scan_sel)
            2'd1: begin
                anodo  = 3'b101;
                digito = dezena;
`ifdef BLANK_ZEROS_EN
                if (centena == 4'd0 && dezena == 4'd0) digito = 4'hF;
`endif
            end
            2'd2: begin
                anodo  = 3'b011;
                digito = centena;
`ifdef BLANK_ZEROS_EN
                if (centena == 4'd0) digito = 4'hF;
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_controlador_display_bcd.sv
// Randomized self-checking bench for controlador_display_bcd against a decimal
// arithmetic reference model (REFRESH_DIV shortened to 4).
module tb_controlador_display_bcd;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_valor;
    logic [3:0] centena, dezena, unidade, digito;
    logic       bcd_valid;
    logic [2:0] anodo;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int n_since_rst = 0;
    int exp_c = 0, exp_d = 0, exp_u = 0;

    controlador_display_bcd #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_valor(in_valor), .centena(centena), .dezena(dezena), .unidade(unidade),
        .bcd_valid(bcd_valid), .digito(digito), .anodo(anodo)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was last released: drives the scan model.
    always @(posedge clk) begin
        if (rst) n_since_rst <= 0;
        else     n_since_rst <= n_since_rst + 1;
    end

    // Drive one value and measure cycles to bcd_valid (0 if it never came).
    task automatic run_conv(input int v, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_valor = 7'(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bcd_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_valor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        chk_cnt++; if (anodo !== 3'b110) $display("FAIL reset_anodo got %b want 110", anodo); else pass_cnt++;
        chk_cnt++; if (digito !== 4'd0) $display("FAIL reset_digito got %h want 0", digito); else pass_cnt++;
        chk_cnt++; if ({centena, dezena, unidade} !== 12'h000)
            $display("FAIL reset_digits got %0d/%0d/%0d want 0/0/0", centena, dezena, unidade); else pass_cnt++;
        chk_cnt++; if (bcd_valid !== 1'b0) $display("FAIL reset_bcd_valid got %b want 0", bcd_valid); else pass_cnt++;
        rst = 1'b0;
        exp_c = 0; exp_d = 0; exp_u = 0;
    endtask

    task automatic test_convert(input int v);
        int lat, want_lat;
        want_lat = v / 100 + (v % 100) / 10 + 2;
        run_conv(v, lat);
        exp_c = v / 100; exp_d = (v / 10) % 10; exp_u = v % 10;
        chk_cnt++; if (lat !== want_lat) $display("FAIL conv_latency v=%0d got %0d want %0d", v, lat, want_lat); else pass_cnt++;
        chk_cnt++; if (centena !== 4'(exp_c) || dezena !== 4'(exp_d) || unidade !== 4'(exp_u))
            $display("FAIL conv_digits v=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                     v, centena, dezena, unidade, exp_c, exp_d, exp_u); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (bcd_valid !== 1'b0) $display("FAIL conv_pulse_width v=%0d got %b want 0", v, bcd_valid); else pass_cnt++;
    endtask

    task automatic test_random();
        test_convert(127);
        test_convert(0);
        test_convert(9);
        test_convert(10);
        test_convert(99);
        test_convert(100);
        for (int i = 0; i < 12; i++) test_convert(int'($urandom_range(0, 127)));
    endtask

    // in_valid held through the conversion must not be queued.
    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_valor = 7'd99;
        @(posedge clk);
        #1 in_valor = 7'd5;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_in_conv got %b want 0", in_ready); else pass_cnt++;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bcd_valid === 1'b1) begin lat = k; break; end
        end
        chk_cnt++; if (lat !== 11 || centena !== 4'd0 || dezena !== 4'd9 || unidade !== 4'd9)
            $display("FAIL b2b_first got lat %0d %0d/%0d/%0d want lat 11 0/9/9", lat, centena, dezena, unidade); else pass_cnt++;
        // The held request is accepted on the edge after bcd_valid rises.
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bcd_valid === 1'b1) begin lat = k; break; end
        end
        chk_cnt++; if (lat !== 2 || centena !== 4'd0 || dezena !== 4'd0 || unidade !== 4'd5)
            $display("FAIL b2b_second got lat %0d %0d/%0d/%0d want lat 2 0/0/5", lat, centena, dezena, unidade); else pass_cnt++;
        exp_c = 0; exp_d = 0; exp_u = 5;
    endtask

    task automatic test_reset_mid_conv();
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_valor = 7'd99;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk_cnt++; if (bcd_valid !== 1'b0 || in_ready !== 1'b1 || anodo !== 3'b110 || digito !== 4'd0 ||
                       {centena, dezena, unidade} !== 12'h000)
            $display("FAIL midreset_state got v%b r%b a%b d%h %0d/%0d/%0d want v0 r1 a110 d0 0/0/0",
                     bcd_valid, in_ready, anodo, digito, centena, dezena, unidade); else pass_cnt++;
        rst = 1'b0;
        exp_c = 0; exp_d = 0; exp_u = 0;
        seen = 0;
        repeat (15) begin @(negedge clk); if (bcd_valid === 1'b1) seen++; end
        chk_cnt++; if (seen !== 0) $display("FAIL midreset_no_result got %0d pulses want 0", seen); else pass_cnt++;
    endtask

    task automatic test_scan(input int v, input int cycles);
        int lat, pos, bad;
        logic [2:0] want_a;
        logic [3:0] want_d;
        run_conv(v, lat);
        exp_c = v / 100; exp_d = (v / 10) % 10; exp_u = v % 10;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            pos = (n_since_rst / DIV) % 3;
            want_a = ~(3'b001 << pos);
            case (pos)
                0: want_d = 4'(exp_u);
                1: want_d = 4'(exp_d);
                default: want_d = 4'(exp_c);
            endcase
`ifdef BLANK_ZEROS_EN
            if (pos == 2 && exp_c == 0) want_d = 4'hF;
            if (pos == 1 && exp_c == 0 && exp_d == 0) want_d = 4'hF;
`endif
            if (anodo !== want_a || digito !== want_d) begin
                if (bad == 0)
                    $display("FAIL scan v=%0d cycle %0d got anodo %b digito %h want %b %h",
                             v, k, anodo, digito, want_a, want_d);
                bad++;
            end
        end
        chk_cnt++; if (bad !== 0) $display("FAIL scan_total v=%0d got %0d bad cycles want 0", v, bad); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_random();
        test_back_to_back();
        test_reset_mid_conv();
        test_scan(127, 30);
        test_scan(5, 24);
        test_scan(100, 24);
        test_scan(0, 24);
        test_scan(int'($urandom_range(0, 127)), 24);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
